// File: rtl/ir_nec_pkg.sv
// -----------------------------------------------------------------------------
// ir_nec_pkg
//   Shared definitions for the NEC IR receiver: FSM state encoding, pulse
//   window limits (in timing ticks), the frame length, and a window-compare
//   helper.
//
//   One tick is TICK_CLKS clk cycles (56.25 us at 50 MHz with the default).
//   The nominal NEC timings in ticks are:
//     leader mark 160, leader space 80, repeat space 40,
//     bit mark 10, zero space 10, one space 30.
//   Each window brackets its nominal value with generous margins so that
//   receiver jitter and the +/-1 tick quantisation of the duration counter
//   never push a legal pulse outside.
// -----------------------------------------------------------------------------
package ir_nec_pkg;

  // Receiver FSM states. Each named state is the level currently being timed.
  typedef enum logic [2:0] {
    ST_IDLE,       // line idle (high), waiting for a leader mark
    ST_LDR_MARK,   // timing the 9 ms leader mark
    ST_LDR_SPACE,  // timing the leader space (data frame or repeat code)
    ST_BIT_MARK,   // timing the 562 us mark that starts every data bit
    ST_BIT_SPACE,  // timing the space that encodes the bit value
    ST_STOP_MARK,  // timing the trailing mark after bit 31
    ST_RPT_MARK    // timing the trailing mark of a repeat code
  } state_t;

  // Inclusive pulse windows, in ticks.
  localparam int LDR_MARK_MIN  = 128;
  localparam int LDR_MARK_MAX  = 192;
  localparam int LDR_SPACE_MIN = 64;
  localparam int LDR_SPACE_MAX = 96;
  localparam int RPT_SPACE_MIN = 32;
  localparam int RPT_SPACE_MAX = 48;
  localparam int BIT_MARK_MIN  = 6;
  localparam int BIT_MARK_MAX  = 14;
  localparam int ZERO_SP_MIN   = 6;
  localparam int ZERO_SP_MAX   = 14;
  localparam int ONE_SP_MIN    = 22;
  localparam int ONE_SP_MAX    = 38;

  // Data bits per frame: addr, ~addr, cmd, ~cmd.
  localparam int FRAME_BITS = 32;

  // True when a measured duration lies inside [lo, hi].
  function automatic logic in_window(input int d, input int lo, input int hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// -----------------------------------------------------------------------------
// ir_tick_gen
//   Free-running prescaler that produces the timing tick for the NEC
//   receiver's pulse-duration counter.
//
// Parameters
//   TICK_CLKS  clk cycles per tick (>= 1)
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   tick  out  1-cycle pulse, once every TICK_CLKS cycles (registered)
// -----------------------------------------------------------------------------
module ir_tick_gen #(
  parameter int TICK_CLKS = 2813
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CLKS - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_nec_receiver.sv
// -----------------------------------------------------------------------------
// ir_nec_receiver
//   Decodes NEC frames from a demodulated, active-low IR receiver into an
//   address byte and a command byte, flags repeat codes and malformed frames,
//   and keeps the last valid command as a 9-bit {sign, magnitude} word for
//   the 7-segment BCD display stage.
//
// Parameters
//   TICK_CLKS  clk cycles per timing tick
//   DUR_W      width of the pulse-duration counter; its all-ones value is the
//              inactivity timeout
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   ir_in  in   raw receiver output, asynchronous; 0 = carrier (mark)
//   addr   out  [7:0] address byte of the last valid frame
//   cmd    out  [7:0] command byte of the last valid frame
//   value  out  [8:0] {1'b0, cmd} for the display stage
//   valid  out  1-cycle pulse: new frame accepted (addr/cmd/value update now)
//   rpt    out  1-cycle pulse: repeat code accepted
//   err    out  1-cycle pulse: frame aborted (window miss / inverse mismatch)
//
// Latency: a pulse appears on the 3rd clk edge after the ir_in transition
// that ends the frame (two synchronizer stages plus the FSM register).
// -----------------------------------------------------------------------------
module ir_nec_receiver
  import ir_nec_pkg::*;
#(
  parameter int TICK_CLKS = 2813,
  parameter int DUR_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic [8:0] value,
  output logic       valid,
  output logic       rpt,
  output logic       err
);

  localparam int BCW = $clog2(FRAME_BITS);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(FRAME_BITS - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect. sync3 is a delayed copy of the settled
  // sample so an edge is seen for exactly one cycle. All three reset to the
  // idle (high) level so leaving reset never fakes an edge.
  // ---------------------------------------------------------------------------
  logic sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  logic fall, rise;
  assign fall = sync3 & ~sync2;   // space -> mark
  assign rise = ~sync3 & sync2;   // mark -> space

  // ---------------------------------------------------------------------------
  // Tick prescaler and pulse-duration counter. On an edge cycle dur still
  // holds the length of the level that just ended; it restarts from 0 on the
  // following cycle. Saturation doubles as the inactivity timeout.
  // ---------------------------------------------------------------------------
  logic tick;

  ir_tick_gen #(
    .TICK_CLKS(TICK_CLKS)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic [DUR_W-1:0] dur;
  logic             dur_sat;

  assign dur_sat = (dur == DUR_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      dur <= '0;
    end else if (rise || fall) begin
      dur <= '0;
    end else if (tick && !dur_sat) begin
      dur <= dur + 1'b1;
    end
  end

  // Window classification of the level that just ended.
  int   dur_i;
  logic win_ldr_mark, win_ldr_space, win_rpt_space;
  logic win_bit_mark, win_zero_sp, win_one_sp;

  assign dur_i         = int'(dur);
  assign win_ldr_mark  = in_window(dur_i, LDR_MARK_MIN,  LDR_MARK_MAX);
  assign win_ldr_space = in_window(dur_i, LDR_SPACE_MIN, LDR_SPACE_MAX);
  assign win_rpt_space = in_window(dur_i, RPT_SPACE_MIN, RPT_SPACE_MAX);
  assign win_bit_mark  = in_window(dur_i, BIT_MARK_MIN,  BIT_MARK_MAX);
  assign win_zero_sp   = in_window(dur_i, ZERO_SP_MIN,   ZERO_SP_MAX);
  assign win_one_sp    = in_window(dur_i, ONE_SP_MIN,    ONE_SP_MAX);

  // ---------------------------------------------------------------------------
  // Frame register, LSB-first: after 32 shifts it reads
  // {cmd_n, cmd, addr_n, addr}. The check looks at the completed word held
  // while the stop mark is being timed.
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] shreg;
  logic                  frame_ok;

  assign frame_ok = ((shreg[7:0]   ^ shreg[15:8])  == 8'hFF) &&
                    ((shreg[23:16] ^ shreg[31:24]) == 8'hFF);

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered outputs. Pulses default low every cycle so
  // at most one of valid/rpt/err can be set, and only for one cycle.
  // ---------------------------------------------------------------------------
  state_t         state;
  logic [BCW-1:0] bit_cnt;
  logic           have_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      have_frame <= 1'b0;
      addr       <= '0;
      cmd        <= '0;
      value      <= '0;
      valid      <= 1'b0;
      rpt        <= 1'b0;
      err        <= 1'b0;
    end else begin
      valid <= 1'b0;
      rpt   <= 1'b0;
      err   <= 1'b0;

      // A level that outlasts the counter abandons the frame quietly; this
      // also recovers from a receiver stuck low.
      if (state != ST_IDLE && dur_sat) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (fall) state <= ST_LDR_MARK;
          end

          ST_LDR_MARK: begin
            // A short or overlong first mark is treated as noise, not an error.
            if (rise) state <= win_ldr_mark ? ST_LDR_SPACE : ST_IDLE;
          end

          ST_LDR_SPACE: begin
            if (fall) begin
              if (win_ldr_space) begin
                bit_cnt <= '0;
                state   <= ST_BIT_MARK;
              end else if (win_rpt_space) begin
                state <= ST_RPT_MARK;
              end else begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end

          ST_BIT_MARK: begin
            if (rise) begin
              if (win_bit_mark) begin
                state <= ST_BIT_SPACE;
              end else begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end

          ST_BIT_SPACE: begin
            if (fall) begin
              if (win_zero_sp || win_one_sp) begin
                shreg <= {win_one_sp, shreg[FRAME_BITS-1:1]};
                if (bit_cnt == LAST_BIT) begin
                  state <= ST_STOP_MARK;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  state   <= ST_BIT_MARK;
                end
              end else begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end

          ST_STOP_MARK: begin
            if (rise) begin
              if (win_bit_mark && frame_ok) begin
                addr       <= shreg[7:0];
                cmd        <= shreg[23:16];
                value      <= {1'b0, shreg[23:16]};
                valid      <= 1'b1;
                have_frame <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              state <= ST_IDLE;
            end
          end

          ST_RPT_MARK: begin
            // A repeat with nothing to repeat, or a bad trailing mark, is
            // dropped without an error.
            if (rise) begin
              if (win_bit_mark && have_frame) rpt <= 1'b1;
              state <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_receiver.sv
// -----------------------------------------------------------------------------
// tb_ir_nec_receiver
//   Self-checking bench for ir_nec_receiver (TICK_CLKS=4). Stimulus is built
//   as a list of (level, ticks) segments with randomized pulse lengths; the
//   expected outcome of each transmission comes from a protocol-level model
//   and is queued. A monitor pops the queue whenever the DUT pulses.
// -----------------------------------------------------------------------------
module tb_ir_nec_receiver;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ir_in;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic [8:0] value;
  logic       valid;
  logic       rpt;
  logic       err;

  always #5 clk = ~clk;

  ir_nec_receiver #(
    .TICK_CLKS(TICK),
    .DUR_W    (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ir_in(ir_in),
    .addr (addr),
    .cmd  (cmd),
    .value(value),
    .valid(valid),
    .rpt  (rpt),
    .err  (err)
  );

  typedef enum int {EV_VALID, EV_RPT, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] addr;
    logic [7:0] cmd;
  } ev_t;

  typedef struct {
    logic lvl;
    int   ticks;
  } seg_t;

  ev_t  exp_q[$];
  seg_t segs[$];

  int checks = 0;
  int errors = 0;

  // Protocol-level model state.
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_cmd  = 8'h00;
  bit         m_have = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] kind_bits(input ev_kind_e k);
    case (k)
      EV_VALID: return 3'b100;
      EV_RPT:   return 3'b010;
      default:  return 3'b001;
    endcase
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : monitor
    ev_t e;
    if (!rst && (valid || rpt || err)) begin
      check("one_pulse", int'(valid) + int'(rpt) + int'(err), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {valid, rpt, err}, 3'b000);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {valid, rpt, err}, kind_bits(e.kind));
        if (e.kind == EV_VALID) begin
          check("valid_addr", addr, e.addr);
          check("valid_cmd", cmd, e.cmd);
          check("valid_value", value, {1'b0, e.cmd});
        end
      end
    end
  end

  // ------------------------------------------------------------------ model
  task automatic expect_frame(input logic [7:0] a, an, c, cn);
    if (((a ^ an) == 8'hFF) && ((c ^ cn) == 8'hFF)) begin
      exp_q.push_back('{EV_VALID, a, c});
      m_addr = a;
      m_cmd  = c;
      m_have = 1'b1;
    end else begin
      exp_q.push_back('{EV_ERR, 8'h00, 8'h00});
    end
  endtask

  task automatic expect_repeat();
    if (m_have) exp_q.push_back('{EV_RPT, 8'h00, 8'h00});
  endtask

  // -------------------------------------------------------------- stimulus
  function automatic int urand(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic add(input logic lvl, input int ticks);
    segs.push_back('{lvl, ticks});
  endtask

  // Leader plus the first nbits data bits of word w (LSB first); no stop mark.
  task automatic build_frame(input logic [31:0] w, input int nbits);
    segs.delete();
    add(1'b0, urand(150, 170));
    add(1'b1, urand(75, 85));
    for (int i = 0; i < nbits; i++) begin
      add(1'b0, urand(8, 12));
      add(1'b1, w[i] ? urand(26, 34) : urand(8, 12));
    end
  endtask

  task automatic play();
    foreach (segs[i]) begin
      ir_in = segs[i].lvl;
      repeat (segs[i].ticks * TICK) @(negedge clk);
    end
    segs.delete();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_addr"}, addr, m_addr);
    check({tag, "_cmd"}, cmd, m_cmd);
    check({tag, "_value"}, value, {1'b0, m_cmd});
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, an, c, cn);
    expect_frame(a, an, c, cn);
    build_frame({cn, c, an, a}, 32);
    add(1'b0, 10);
    add(1'b1, 40);
    play();
    check_outputs(tag);
  endtask

  task automatic send_repeat(input string tag);
    expect_repeat();
    segs.delete();
    add(1'b0, urand(150, 170));
    add(1'b1, urand(38, 42));
    add(1'b0, 10);
    add(1'b1, 40);
    play();
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ir_in = 1'b1;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_addr = 8'h00;
    m_cmd  = 8'h00;
    m_have = 1'b0;
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    logic [7:0] a, an, c, cn;

    rst   = 1'b1;
    ir_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and a quiet line.
    check("rst_addr", addr, 8'h00);
    check("rst_cmd", cmd, 8'h00);
    check("rst_value", value, 9'h000);
    check("rst_pulses", {valid, rpt, err}, 3'b000);
    repeat (1000) @(negedge clk);
    check_outputs("idle");

    // Good frame, then the same frame with a bad inverse command.
    send_frame("frame45", 8'h00, 8'hFF, 8'h45, 8'hBA);
    send_frame("badinv", 8'h00, 8'hFF, 8'h45, 8'hBB);
    check("hold_value_045", value, 9'h045);

    // Repeat after a frame, then a repeat straight after reset.
    send_repeat("repeat");
    do_reset();
    send_repeat("repeat_norst");
    check("post_rst_value", value, 9'h000);

    // Short leader mark is noise: silent.
    segs.delete();
    add(1'b0, 60);
    add(1'b1, 40);
    play();
    check_outputs("noise");

    // Receiver stuck low after bit 12: silent timeout, then a good frame.
    build_frame({8'h66, 8'h99, 8'hEF, 8'h10}, 13);
    add(1'b0, 300);
    add(1'b1, 40);
    play();
    check_outputs("stuck");
    send_frame("frame16", 8'h10, 8'hEF, 8'h16, 8'hE9);
    check("value_016", value, 9'h016);

    // Bit space between the zero and one windows: err.
    build_frame({8'hC3, 8'h3C, 8'hFE, 8'h01}, 5);
    add(1'b0, 10);
    add(1'b1, 18);
    add(1'b0, 10);
    add(1'b1, 40);
    exp_q.push_back('{EV_ERR, 8'h00, 8'h00});
    play();
    check_outputs("badspace");

    // Reset in the middle of bit 20, then a full frame.
    build_frame({8'hC3, 8'h3C, 8'h5A, 8'hA5}, 20);
    add(1'b0, 10);
    add(1'b1, 5);
    play();
    do_reset();
    check_outputs("midrst");
    send_frame("after_rst", 8'hA5, 8'h5A, 8'h3C, 8'hC3);

    // Randomized frames, some with a corrupted inverse byte, some repeated.
    for (int n = 0; n < 3; n++) begin
      a  = 8'($urandom);
      c  = 8'($urandom);
      an = ~a;
      cn = ~c;
      if (urand(0, 2) == 0) begin
        if (urand(0, 1) == 0) an = an ^ (8'h01 << urand(0, 7));
        else                  cn = cn ^ (8'h01 << urand(0, 7));
      end
      send_frame("rand", a, an, c, cn);
      check("rand_value_msb", value[8], 1'b0);
      if (urand(0, 1) == 1) send_repeat("rand_repeat");
    end

    repeat (50) @(negedge clk);
    check("final_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
